game_ctrl: RTL and testbench

//   Game controller that drives the snake drawing block: produces direction, game_state and the
//   one-cycle update (step) strobe. Consumes that block's snake_head_active / snake_body_active

---
 rtl/game_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_game_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: snake game controller. Turns raw buttons into a committed
// direction, runs the IDLE/PLAY/GAME_OVER flow on frame_tick, and issues a
// one-cycle update strobe every FRAMES_PER_STEP frames. During PLAY it watches
// the snake pixel flags in the visible area to detect self-collision and a
// head that has left the screen.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   btn_up/down/left/right        raw buttons, asynchronous to clk
//   x_pos, y_pos [BIT]            current scan position
//   frame_tick                    one-cycle pulse per frame (vertical blanking)
//   snake_head_active/body_active snake drawing flags at (x_pos, y_pos)
//   direction [3]                 IDLE=000 UP=001 DOWN=010 LEFT=011 RIGHT=100
//   game_state [2]                IDLE=00 PLAY=01 GAME_OVER=11
//   update                        one-cycle step strobe
module game_ctrl #(
  parameter int unsigned BIT             = 10,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned OVER_FRAMES     = 120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic           frame_tick,
  input  logic           snake_head_active,
  input  logic           snake_body_active,
  output logic [2:0]     direction,
  output logic [1:0]     game_state,
  output logic           update
);

  localparam int unsigned STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned OVER_W = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(OVER_FRAMES - 1);
  localparam logic [BIT-1:0]    H_LIM     = BIT'(H_ACTIVE);
  localparam logic [BIT-1:0]    V_LIM     = BIT'(V_ACTIVE);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b11;

  localparam logic [2:0] DIR_IDLE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  // Button vector bit order: [0]=up [1]=down [2]=left [3]=right
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, sync3_q, edge_q;

  logic [1:0]        state_q, state_d;
  logic [2:0]        dir_q, dir_d;
  logic [2:0]        pend_q, pend_d;
  logic              update_q, update_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OVER_W-1:0] over_q, over_d;
  logic              hit_q, hit_d;
  logic              seen_q, seen_d;

  logic [2:0] btn_sel;
  logic [2:0] dir_rev;
  logic       visible;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};
  assign visible = (x_pos < H_LIM) && (y_pos < V_LIM);

  // Synchroniser plus registered rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // Same-cycle edges resolve UP > DOWN > LEFT > RIGHT
  always_comb begin
    btn_sel = DIR_IDLE;
    if      (edge_q[0]) btn_sel = DIR_UP;
    else if (edge_q[1]) btn_sel = DIR_DOWN;
    else if (edge_q[2]) btn_sel = DIR_LEFT;
    else if (edge_q[3]) btn_sel = DIR_RIGHT;
  end

  // Reverse of the committed direction; such an edge is dropped
  always_comb begin
    dir_rev = DIR_IDLE;
    case (dir_q)
      DIR_UP:    dir_rev = DIR_DOWN;
      DIR_DOWN:  dir_rev = DIR_UP;
      DIR_LEFT:  dir_rev = DIR_RIGHT;
      DIR_RIGHT: dir_rev = DIR_LEFT;
      default:   dir_rev = DIR_IDLE;
    endcase
  end

  // Next-state and scan-monitor logic
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    update_d = 1'b0;
    step_d   = step_q;
    over_d   = over_q;
    hit_d    = hit_q;
    seen_d   = seen_q;

    // Flags are consumed by the FSM on frame_tick (old values) and cleared
    if (frame_tick) begin
      hit_d  = 1'b0;
      seen_d = 1'b0;
    end else if (state_q == ST_PLAY && visible) begin
      seen_d = seen_q | snake_head_active;
      hit_d  = hit_q | (snake_head_active & snake_body_active);
    end

    case (state_q)
      ST_IDLE: begin
        dir_d = DIR_IDLE;
        if (btn_sel != DIR_IDLE) begin
          state_d = ST_PLAY;
          dir_d   = btn_sel;
          pend_d  = btn_sel;
          step_d  = '0;
        end
      end
      ST_PLAY: begin
        if (btn_sel != DIR_IDLE && btn_sel != dir_rev) pend_d = btn_sel;
        if (frame_tick) begin
          if (hit_q || !seen_q) begin
            state_d = ST_OVER;
            dir_d   = DIR_IDLE;
            step_d  = '0;
            over_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d   = '0;
            update_d = 1'b1;
            dir_d    = pend_q;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (over_q == OVER_LAST) begin
            state_d = ST_IDLE;
            over_d  = '0;
          end else begin
            over_d = over_q + OVER_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        dir_d   = DIR_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_IDLE;
      pend_q   <= DIR_IDLE;
      update_q <= 1'b0;
      step_q   <= '0;
      over_q   <= '0;
      hit_q    <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      update_q <= update_d;
      step_q   <= step_d;
      over_q   <= over_d;
      hit_q    <= hit_d;
      seen_q   <= seen_d;
    end
  end

  assign direction  = dir_q;
  assign game_state = state_q;
  assign update     = update_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed button/scan/frame stimulus, a behavioural
// game model compared every cycle, plus hand-computed literal expectations.
module tb_game_ctrl;

  localparam int BIT = 10;
  localparam int H   = 640;
  localparam int V   = 480;
  localparam int FPS = 4;
  localparam int OF  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [BIT-1:0] x_pos = '0, y_pos = '0;
  logic           frame_tick = 1'b0;
  logic           snake_head_active = 1'b0, snake_body_active = 1'b0;
  logic [2:0]     direction;
  logic [1:0]     game_state;
  logic           update;

  int checks = 0;
  int failures = 0;
  int upd_seen = 0;
  bit cmp_en = 1'b0;

  game_ctrl #(
    .BIT(BIT), .H_ACTIVE(H), .V_ACTIVE(V),
    .FRAMES_PER_STEP(FPS), .OVER_FRAMES(OF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .x_pos(x_pos), .y_pos(y_pos), .frame_tick(frame_tick),
    .snake_head_active(snake_head_active), .snake_body_active(snake_body_active),
    .direction(direction), .game_state(game_state), .update(update)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  // states: 0 idle, 1 play, 3 game over; directions 0..4
  int m_state, m_dir, m_pend, m_step, m_over;
  bit m_upd, m_head, m_hit;
  bit [3:0] hist [5];   // raw button samples, [0] = this edge

  function automatic int opposite(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int btn, ns, nd, np, nstep, nover;
    bit nupd, vis;
    bit [3:0] edges;
    if (!rst_n) begin
      m_state = 0; m_dir = 0; m_pend = 0; m_step = 0; m_over = 0;
      m_upd = 0; m_head = 0; m_hit = 0;
      for (int i = 0; i < 5; i++) hist[i] = 4'b0;
    end else begin
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {btn_right, btn_left, btn_down, btn_up};
      // a press is acted on 3 clocks after it is first sampled
      edges = hist[3] & ~hist[4];
      btn = edges[0] ? 1 : edges[1] ? 2 : edges[2] ? 3 : edges[3] ? 4 : 0;
      vis = (int'(x_pos) < H) && (int'(y_pos) < V);
      ns = m_state; nd = m_dir; np = m_pend; nstep = m_step; nover = m_over; nupd = 0;
      if (m_state == 0) begin
        if (btn != 0) begin ns = 1; nd = btn; np = btn; nstep = 0; end
      end else if (m_state == 1) begin
        if (btn != 0 && btn != opposite(m_dir)) np = btn;
        if (frame_tick) begin
          if (m_hit || !m_head) begin ns = 3; nd = 0; nstep = 0; nover = 0; end
          else if (m_step == FPS - 1) begin nstep = 0; nupd = 1; nd = m_pend; end
          else nstep = m_step + 1;
        end
      end else begin
        if (frame_tick) begin
          if (m_over == OF - 1) begin ns = 0; nover = 0; end
          else nover = m_over + 1;
        end
      end
      if (frame_tick) begin
        m_head = 0; m_hit = 0;
      end else if (m_state == 1 && vis) begin
        m_head = m_head | snake_head_active;
        m_hit  = m_hit | (snake_head_active & snake_body_active);
      end
      m_state = ns; m_dir = nd; m_pend = np; m_step = nstep; m_over = nover; m_upd = nupd;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("model_game_state", int'(game_state), m_state);
      check("model_direction", int'(direction), m_dir);
      check("model_update", int'(update), int'(m_upd));
      if (update === 1'b1) upd_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic scan_frame(input bit hd, input bit bd);
    @(negedge clk); x_pos = 10'd100; y_pos = 10'd100;
    snake_head_active = hd; snake_body_active = bd;
    @(negedge clk); x_pos = 10'd200; y_pos = 10'd50;
    snake_head_active = 1'b0; snake_body_active = 1'b0;
    // off-screen pixel with both flags high must not count
    @(negedge clk); x_pos = 10'd700; y_pos = 10'd100;
    snake_head_active = 1'b1; snake_body_active = 1'b1;
    @(negedge clk); x_pos = '0; y_pos = '0;
    snake_head_active = 1'b0; snake_body_active = 1'b0;
  endtask

  task automatic press(input bit [3:0] b);
    @(negedge clk); {btn_right, btn_left, btn_down, btn_up} = b;
    repeat (6) @(negedge clk);
    {btn_right, btn_left, btn_down, btn_up} = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("reset_state", int'(game_state), 0);
    check("reset_dir", int'(direction), 0);
    check("reset_update", int'(update), 0);

    // IDLE -> PLAY on right, 3 cycles of sync/edge latency
    @(negedge clk); btn_right = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("idle_before_edge", int'(game_state), 0);
    @(negedge clk);
    #1 check("play_entry_state", int'(game_state), 1);
    check("play_entry_dir", int'(direction), 4);
    repeat (3) @(negedge clk);
    btn_right = 1'b0;

    // 8 frames with visible head: updates after ticks 4 and 8 only
    upd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      scan_frame(1'b1, 1'b0);
      tick();
      #1 check($sformatf("update_after_tick%0d", i + 1), int'(update), (i == 3 || i == 7) ? 1 : 0);
    end
    @(negedge clk);
    #1 check("update_pulse_count", upd_seen, 2);

    // left is the reverse of right: dropped
    press(4'b0100);
    for (int i = 0; i < 4; i++) begin scan_frame(1'b1, 1'b0); tick(); end
    #1 check("reverse_ignored_dir", int'(direction), 4);
    check("reverse_ignored_update", int'(update), 1);
    press(4'b0001);
    check("pending_not_committed", int'(direction), 4);
    for (int i = 0; i < 4; i++) begin scan_frame(1'b1, 1'b0); tick(); end
    #1 check("up_committed_dir", int'(direction), 1);

    // self-collision at (100,100)
    scan_frame(1'b1, 1'b1);
    tick();
    #1 check("hit_state", int'(game_state), 3);
    check("hit_no_update", int'(update), 0);
    check("hit_dir", int'(direction), 0);
    press(4'b0010);
    #1 check("over_ignores_button", int'(game_state), 3);
    tick(); tick();
    #1 check("over_after_2_ticks", int'(game_state), 3);
    tick();
    #1 check("over_to_idle", int'(game_state), 0);

    // simultaneous up+right: up wins; then head leaves the screen
    press(4'b1001);
    #1 check("priority_state", int'(game_state), 1);
    check("priority_dir", int'(direction), 1);
    scan_frame(1'b1, 1'b0);
    tick();
    #1 check("alive_frame", int'(game_state), 1);
    scan_frame(1'b0, 1'b0);
    tick();
    #1 check("head_offscreen_over", int'(game_state), 3);
    repeat (3) tick();
    #1 check("offscreen_back_idle", int'(game_state), 0);

    // async reset mid-PLAY, between clock edges
    press(4'b0010);
    #1 check("pre_reset_state", int'(game_state), 1);
    check("pre_reset_dir", int'(direction), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_state", int'(game_state), 0);
    check("async_reset_dir", int'(direction), 0);
    check("async_reset_update", int'(update), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("post_reset_idle", int'(game_state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
